// File: rtl/scarv_cop_issue.sv
// Issue stage for the COP: latches one CPU instruction, registers the decoder verdict,
// issues to the functional units under a watchdog and returns one response per instruction.
`timescale 1ns/1ps
module scarv_cop_issue #(
  parameter int unsigned FU_TIMEOUT = 255,
  parameter int unsigned CW         = 8
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        cpu_insn_req,
  output logic        cpu_insn_ack,
  input  logic [31:0] cpu_insn_enc,
  input  logic [31:0] cpu_rs1,
  output logic [31:0] id_encoded,
  input  logic        id_exception,
  input  logic [8:0]  id_class,
  input  logic [4:0]  id_rd,
  output logic        fu_valid,
  input  logic        fu_ready,
  output logic [8:0]  fu_class,
  output logic [31:0] fu_rs1,
  input  logic        fu_done,
  input  logic        fu_error,
  input  logic        fu_wen,
  input  logic [31:0] fu_wdata,
  output logic        fu_flush,
  output logic        cpu_rsp_valid,
  input  logic        cpu_rsp_ready,
  output logic [2:0]  cpu_rsp_status,
  output logic [4:0]  cpu_rsp_rd,
  output logic        cpu_rsp_wen,
  output logic [31:0] cpu_rsp_wdata,
  output logic        busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  localparam logic [2:0] RSP_OK      = 3'd0;
  localparam logic [2:0] RSP_ILLEGAL = 3'd1;
  localparam logic [2:0] RSP_TIMEOUT = 3'd2;
  localparam logic [2:0] RSP_FU_ERR  = 3'd3;

  // A zero timeout disables the watchdog; TO_LAST is then never compared.
  localparam logic           WDOG_EN = (FU_TIMEOUT != 0);
  localparam logic [CW-1:0]  TO_LAST = CW'(FU_TIMEOUT - 1);

  logic [2:0]    state_q,     state_d;
  logic [31:0]   enc_q,       enc_d;
  logic [31:0]   rs1_q,       rs1_d;
  logic [8:0]    class_q,     class_d;
  logic [4:0]    rd_q,        rd_d;
  logic          fu_valid_q,  fu_valid_d;
  logic          flush_q,     flush_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [2:0]    status_q,    status_d;
  logic          wen_q,       wen_d;
  logic [31:0]   wdata_q,     wdata_d;

  logic insn_ack_s;
  logic complete_s;
  logic expire_s;
  logic cap_wen_s;

  assign complete_s = ((state_q == ST_ISSUE) & fu_ready & fu_done) |
                      ((state_q == ST_WAIT) & fu_done);
  assign expire_s   = WDOG_EN & (cnt_q == TO_LAST);
  assign cap_wen_s  = fu_wen & ~fu_error;

  // Next-state and datapath update for the issue FSM.
  always_comb begin
    state_d     = state_q;
    enc_d       = enc_q;
    rs1_d       = rs1_q;
    class_d     = class_q;
    rd_d        = rd_q;
    fu_valid_d  = fu_valid_q;
    flush_d     = 1'b0;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    status_d    = status_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    insn_ack_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        insn_ack_s = cpu_insn_req;
        if (cpu_insn_req) begin
          enc_d   = cpu_insn_enc;
          rs1_d   = cpu_rs1;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        class_d = id_class;
        rd_d    = id_rd;
        if (id_exception) begin
          status_d    = RSP_ILLEGAL;
          wen_d       = 1'b0;
          wdata_d     = 32'd0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d      = {CW{1'b0}};
          fu_valid_d = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Completion in the expiry cycle takes priority over the watchdog.
        if (complete_s) begin
          status_d    = fu_error ? RSP_FU_ERR : RSP_OK;
          wen_d       = cap_wen_s;
          wdata_d     = cap_wen_s ? fu_wdata : 32'd0;
          fu_valid_d  = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (expire_s) begin
          status_d    = RSP_TIMEOUT;
          wen_d       = 1'b0;
          wdata_d     = 32'd0;
          flush_d     = 1'b1;
          fu_valid_d  = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if ((state_q == ST_ISSUE) && fu_ready) begin
          fu_valid_d = 1'b0;
          state_d    = ST_WAIT;
        end else begin
          state_d = state_q;
        end
      end
      ST_RESP: begin
        if (cpu_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        fu_valid_d  = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q     <= ST_IDLE;
      enc_q       <= 32'd0;
      rs1_q       <= 32'd0;
      class_q     <= 9'd0;
      rd_q        <= 5'd0;
      fu_valid_q  <= 1'b0;
      flush_q     <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      rsp_valid_q <= 1'b0;
      status_q    <= 3'd0;
      wen_q       <= 1'b0;
      wdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      enc_q       <= enc_d;
      rs1_q       <= rs1_d;
      class_q     <= class_d;
      rd_q        <= rd_d;
      fu_valid_q  <= fu_valid_d;
      flush_q     <= flush_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      status_q    <= status_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
    end
  end

  assign cpu_insn_ack   = insn_ack_s;
  assign id_encoded     = enc_q;
  assign fu_valid       = fu_valid_q;
  assign fu_class       = class_q;
  assign fu_rs1         = rs1_q;
  assign fu_flush       = flush_q;
  assign cpu_rsp_valid  = rsp_valid_q;
  assign cpu_rsp_status = status_q;
  assign cpu_rsp_rd     = rd_q;
  assign cpu_rsp_wen    = wen_q;
  assign cpu_rsp_wdata  = wdata_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_scarv_cop_issue.sv
// Randomized scoreboard bench for scarv_cop_issue: a driver pushes model predictions,
// a negedge monitor pops and compares them at each response handshake.
`timescale 1ns/1ps
module tb_scarv_cop_issue;

  localparam int TO = 8;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        cpu_insn_req;
  logic        cpu_insn_ack;
  logic [31:0] cpu_insn_enc;
  logic [31:0] cpu_rs1;
  logic [31:0] id_encoded;
  logic        id_exception;
  logic [8:0]  id_class;
  logic [4:0]  id_rd;
  logic        fu_valid;
  logic        fu_ready;
  logic [8:0]  fu_class;
  logic [31:0] fu_rs1;
  logic        fu_done;
  logic        fu_error;
  logic        fu_wen;
  logic [31:0] fu_wdata;
  logic        fu_flush;
  logic        cpu_rsp_valid;
  logic        cpu_rsp_ready;
  logic [2:0]  cpu_rsp_status;
  logic [4:0]  cpu_rsp_rd;
  logic        cpu_rsp_wen;
  logic [31:0] cpu_rsp_wdata;
  logic        busy;

  scarv_cop_issue #(.FU_TIMEOUT(TO), .CW(8)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .cpu_insn_req(cpu_insn_req), .cpu_insn_ack(cpu_insn_ack),
    .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
    .id_encoded(id_encoded), .id_exception(id_exception),
    .id_class(id_class), .id_rd(id_rd),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_class(fu_class), .fu_rs1(fu_rs1),
    .fu_done(fu_done), .fu_error(fu_error), .fu_wen(fu_wen), .fu_wdata(fu_wdata),
    .fu_flush(fu_flush),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
    .cpu_rsp_status(cpu_rsp_status), .cpu_rsp_rd(cpu_rsp_rd),
    .cpu_rsp_wen(cpu_rsp_wen), .cpu_rsp_wdata(cpu_rsp_wdata),
    .busy(busy)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [2:0]  status;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] wdata;
    int          lat;
    int          flushes;
    int          vcyc;
    logic [8:0]  cls;
    logic [31:0] enc;
    logic [31:0] rs1;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  // Reference: completion lands rdy+dne cycles after issue entry; it counts only if
  // it falls inside the TO-cycle window, otherwise the watchdog answers at issue+TO.
  function automatic exp_t model(input logic exc, input logic [4:0] rd, input logic [8:0] cls,
                                 input logic [31:0] enc, input logic [31:0] rs1,
                                 input int rdy, input int dne, input logic err,
                                 input logic wen, input logic [31:0] wd);
    exp_t e;
    int c;
    e.rd = rd; e.cls = cls; e.enc = enc; e.rs1 = rs1;
    e.flushes = 0; e.wen = 1'b0; e.wdata = 32'd0;
    if (exc) begin
      e.status = 3'd1; e.lat = 2; e.vcyc = 0;
    end else begin
      c = rdy + dne;
      if (c <= TO - 1) begin
        e.status = err ? 3'd3 : 3'd0;
        e.wen    = wen & ~err;
        e.wdata  = e.wen ? wd : 32'd0;
        e.lat    = c + 3;
        e.vcyc   = rdy + 1;
      end else begin
        e.status  = 3'd2;
        e.lat     = TO + 2;
        e.flushes = 1;
        e.vcyc    = (rdy + 1 < TO) ? rdy + 1 : TO;
      end
    end
    return e;
  endfunction

  // Monitor: accumulates per-instruction observations and checks them at the handshake.
  initial begin
    int cyc, ack_cyc, flush_cnt, vcnt, lat;
    logic rsp_seen;
    logic [63:0] snap;
    logic [8:0] last_cls;
    exp_t e;
    cyc = 0; ack_cyc = 0; flush_cnt = 0; vcnt = 0; lat = 0;
    rsp_seen = 1'b0; snap = 64'd0; last_cls = 9'd0;
    forever begin
      @(negedge g_clk);
      cyc++;
      if (g_reset) begin
        rsp_seen = 1'b0; flush_cnt = 0; vcnt = 0;
      end else begin
        if (cpu_insn_ack) begin
          ack_cyc = cyc; flush_cnt = 0; vcnt = 0;
        end
        if (fu_flush) flush_cnt++;
        if (fu_valid) begin
          vcnt++; last_cls = fu_class;
        end
        if (cpu_rsp_valid) begin
          chk("ack_blocked_in_resp", {63'd0, cpu_insn_ack}, 64'd0);
          if (!rsp_seen) begin
            rsp_seen = 1'b1;
            lat  = cyc - ack_cyc;
            snap = {23'd0, cpu_rsp_status, cpu_rsp_rd, cpu_rsp_wen, cpu_rsp_wdata};
          end else begin
            chk("rsp_stable", {23'd0, cpu_rsp_status, cpu_rsp_rd, cpu_rsp_wen, cpu_rsp_wdata}, snap);
          end
          if (cpu_rsp_ready) begin
            chk("sb_nonempty", {63'd0, sb.size() > 0}, 64'd1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              chk("status",     cpu_rsp_status, e.status);
              chk("rd",         cpu_rsp_rd,     e.rd);
              chk("wen",        cpu_rsp_wen,    e.wen);
              chk("wdata",      cpu_rsp_wdata,  e.wdata);
              chk("latency",    lat,            e.lat);
              chk("flushes",    flush_cnt,      e.flushes);
              chk("fu_valid_cycles", vcnt,      e.vcyc);
              chk("id_encoded", id_encoded,     e.enc);
              chk("fu_rs1",     fu_rs1,         e.rs1);
              chk("busy_resp",  busy,           1);
              if (e.vcyc > 0) chk("fu_class", last_cls, e.cls);
            end
            rsp_seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic run_insn(input logic exc, input logic [4:0] rd, input logic [8:0] cls,
                          input int rdy, input int dne, input logic err, input logic wen,
                          input logic [31:0] wd, input int hold);
    exp_t e;
    int n;
    cpu_insn_req = 1'b1;
    #1;
    n = 0;
    while (!cpu_insn_ack && n < 20) begin step(); n++; end
    chk("ack_wait", {63'd0, cpu_insn_ack}, 64'd1);
    e = model(exc, rd, cls, cpu_insn_enc, cpu_rs1, rdy, dne, err, wen, wd);
    sb.push_back(e);
    step();
    cpu_insn_req = 1'b0;
    id_exception = exc; id_class = cls; id_rd = rd;
    fu_ready = 1'($urandom_range(0, 1));
    fu_done  = 1'($urandom_range(0, 1));
    if (!exc) begin
      for (int j = 0; j <= rdy + dne; j++) begin
        step();
        fu_ready = (j == rdy);
        fu_done  = (j == rdy + dne);
        fu_error = (j == rdy + dne) ? err : 1'($urandom_range(0, 1));
        fu_wen   = (j == rdy + dne) ? wen : 1'($urandom_range(0, 1));
        fu_wdata = (j == rdy + dne) ? wd  : $urandom;
      end
    end
    step();
    fu_ready = 1'b0; fu_done = 1'b0;
    n = 0;
    while (!cpu_rsp_valid && n < 40) begin step(); n++; end
    chk("rsp_wait", {63'd0, cpu_rsp_valid}, 64'd1);
    cpu_insn_enc = $urandom; cpu_rs1 = $urandom;
    cpu_insn_req = 1'($urandom_range(0, 1));
    repeat (hold) step();
    cpu_rsp_ready = 1'b1;
    cpu_insn_req  = 1'b1;
    step();
    cpu_rsp_ready = 1'b0;
  endtask

  // Driver: reset, directed cases, a mid-instruction reset, then random traffic.
  initial begin
    int n;
    g_reset = 1'b1; cpu_insn_req = 1'b0; cpu_insn_enc = 32'h0; cpu_rs1 = 32'h0;
    id_exception = 1'b0; id_class = 9'd0; id_rd = 5'd0;
    fu_ready = 1'b0; fu_done = 1'b0; fu_error = 1'b0; fu_wen = 1'b0; fu_wdata = 32'h0;
    cpu_rsp_ready = 1'b0;
    repeat (3) step();
    chk("rst_busy",       busy,          0);
    chk("rst_fu_valid",   fu_valid,      0);
    chk("rst_rsp_valid",  cpu_rsp_valid, 0);
    chk("rst_fu_flush",   fu_flush,      0);
    chk("rst_id_encoded", id_encoded,    0);
    chk("rst_fu_rs1",     fu_rs1,        0);
    chk("rst_rsp_wdata",  cpu_rsp_wdata, 0);
    g_reset = 1'b0;
    step();

    cpu_insn_enc = 32'h0A5C_3F2B; cpu_rs1 = 32'h1234_5678;
    run_insn(1'b0, 5'd3, 9'h004, 0, 0, 1'b0, 1'b0, 32'h5555_AAAA, 0);
    cpu_insn_enc = 32'hFFFF_FFFF;
    run_insn(1'b1, 5'd7, 9'h001, 0, 0, 1'b0, 1'b0, 32'h0, 1);
    cpu_insn_enc = 32'h0000_1E2B;
    run_insn(1'b0, 5'd5, 9'h010, 2, 3, 1'b0, 1'b1, 32'hDEAD_BEEF, 0);
    run_insn(1'b0, 5'd9, 9'h002, 0, 30, 1'b0, 1'b1, 32'h1111_2222, 0);
    run_insn(1'b0, 5'd12, 9'h080, 1, 1, 1'b1, 1'b1, 32'hCAFE_F00D, 5);
    run_insn(1'b0, 5'd1, 9'h100, TO - 1, 0, 1'b0, 1'b1, 32'h0BAD_F00D, 0);
    run_insn(1'b0, 5'd2, 9'h020, TO - 1, 1, 1'b0, 1'b1, 32'h7777_7777, 0);

    // Reset while the instruction sits in WAIT: abandoned without response or flush.
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'h3333_4444;
    #1;
    n = 0;
    while (!cpu_insn_ack && n < 20) begin step(); n++; end
    chk("ack_wait_rst", {63'd0, cpu_insn_ack}, 64'd1);
    step(); cpu_insn_req = 1'b0; id_exception = 1'b0; id_class = 9'h008; id_rd = 5'd4;
    step(); fu_ready = 1'b1; fu_done = 1'b0;
    step(); fu_ready = 1'b0;
    step(); g_reset = 1'b1;
    step(); g_reset = 1'b0;
    chk("wrst_busy",      busy,          0);
    chk("wrst_rsp_valid", cpu_rsp_valid, 0);
    chk("wrst_fu_valid",  fu_valid,      0);
    chk("wrst_fu_flush",  fu_flush,      0);

    for (int i = 0; i < 150; i++) begin
      run_insn(($urandom_range(0, 7) == 0), 5'($urandom), 9'd1 << $urandom_range(0, 8),
               int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
               ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom,
               int'($urandom_range(0, 3)));
    end

    cpu_insn_req = 1'b0;
    repeat (5) step();
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/scarv_cop_issue.md
Name: scarv_cop_issue

Overview:
- Sits directly upstream of the COP instruction decoder, between the host CPU coprocessor interface and the COP functional units.
- Accepts one instruction at a time from the CPU and holds its encoding stable on id_encoded.
- Registers the decoder's verdict, then either issues the instruction to the functional units or rejects it as illegal.
- Waits for completion (with a watchdog) and returns a single response per instruction to the CPU.

Parameters:
- FU_TIMEOUT, 255: cycles allowed in ISSUE+WAIT before the instruction is abandoned; 0 disables the watchdog.
- CW, 8: width of the watchdog counter; FU_TIMEOUT must be < 2**CW.

Ports:
- g_clk  in  1  core clock.
- g_reset  in  1  synchronous reset, active-high.
- cpu_insn_req  in  1  CPU presents an instruction.
- cpu_insn_ack  out  1  instruction accepted this cycle.
- cpu_insn_enc  in  32  instruction encoding.
- cpu_rs1  in  32  GPR rs1 value accompanying the instruction.
- id_encoded  out  32  latched encoding driven to the decoder.
- id_exception  in  1  decoder illegal-instruction flag.
- id_class  in  9  decoder one-hot class.
- id_rd  in  5  decoder GPR destination.
- fu_valid  out  1  issue request to the functional units.
- fu_ready  in  1  functional unit accepts the issue.
- fu_class  out  9  registered class, valid while fu_valid.
- fu_rs1  out  32  latched rs1 value.
- fu_done  in  1  functional unit completion pulse.
- fu_error  in  1  functional unit fault, qualified by fu_done.
- fu_wen  in  1  GPR write requested, qualified by fu_done.
- fu_wdata  in  32  GPR write data, qualified by fu_done.
- fu_flush  out  1  one-cycle abort pulse on watchdog expiry.
- cpu_rsp_valid  out  1  response valid.
- cpu_rsp_ready  in  1  CPU accepts the response.
- cpu_rsp_status  out  3  0 OK, 1 illegal, 2 timeout, 3 FU error.
- cpu_rsp_rd  out  5  GPR destination.
- cpu_rsp_wen  out  1  CPU must write cpu_rsp_wdata to GPR cpu_rsp_rd.
- cpu_rsp_wdata  out  32  GPR write data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, DECODE, ISSUE, WAIT, RESP.
- Reset (synchronous, g_reset high):
  - state=IDLE; every registered output and internal latch is 0; fu_flush=0.
  - Reset mid-instruction silently abandons it: no response, no flush.
- IDLE:
  - cpu_insn_ack = cpu_insn_req, combinational, only in IDLE; it is 0 in every other state.
  - On ack, latch cpu_insn_enc into the id_encoded register and cpu_rs1 into fu_rs1, then go to DECODE.
- DECODE (exactly one cycle):
  - Sample id_exception, id_class and id_rd into registers.
  - If id_exception: go to RESP with status=1, wen=0, wdata=0.
  - Otherwise: clear the watchdog and go to ISSUE.
- ISSUE:
  - fu_valid=1 and fu_class stable.
  - On fu_ready: if fu_done is also high, capture results and go to RESP; otherwise go to WAIT.
- WAIT:
  - fu_valid=0.
  - On fu_done, capture results and go to RESP.
  - fu_done outside ISSUE/WAIT is ignored.
- Result capture:
  - status = fu_error ? 3 : 0.
  - cpu_rsp_wen = fu_wen & ~fu_error.
  - cpu_rsp_wdata = fu_wdata when wen, else 0.
  - cpu_rsp_rd = registered id_rd.
- Watchdog (FU_TIMEOUT != 0):
  - Counter increments every cycle in ISSUE and WAIT.
  - When counter == FU_TIMEOUT-1 and no completion occurs that cycle: fu_flush pulses for 1 cycle, fu_valid drops, and the FSM goes to RESP with status=2, wen=0.
  - A completion in the expiry cycle wins over the timeout.
- RESP:
  - cpu_rsp_valid=1; all rsp outputs held stable until cpu_rsp_ready, then go to IDLE.
  - cpu_rsp_valid clears the cycle after the handshake.
  - A new request cannot be acked in the same cycle as the response handshake.
- id_encoded holds its value until the next ack; it is not cleared on return to IDLE.
- Minimum latency (ready/done immediate, rsp_ready high): ack at cycle 0, fu_valid at cycle 2, rsp_valid at cycle 3, next ack at cycle 4.

Test Plan:
- Legal packed-arith instruction, fu_ready=fu_done=1 in the ISSUE cycle, fu_wen=0 -> cpu_rsp_valid at cycle 3, status=0, wen=0; id_encoded equals the encoding from cycle 1 onward.
- Decoder drives id_exception=1 -> fu_valid never asserts; rsp at cycle 2 with status=1, wen=0.
- Move instruction with id_rd=5, fu_ready after 2 cycles, fu_done 3 cycles later with fu_wen=1, fu_wdata=0xDEADBEEF -> rsp status=0, rd=5, wen=1, wdata=0xDEADBEEF.
- FU_TIMEOUT=4, fu_ready=1, fu_done never asserted -> fu_flush pulses exactly once, 4 cycles after ISSUE entry; rsp status=2, wen=0.
- fu_done with fu_error=1 and fu_wen=1 -> status=3, wen=0; cpu_rsp_ready held low 5 cycles -> rsp outputs stable and cpu_insn_ack=0 despite cpu_insn_req=1.
- g_reset asserted in WAIT -> next cycle busy=0, cpu_rsp_valid=0, fu_valid=0, fu_flush=0; a following request is acked normally.
